// File: rtl/axi_demux_ar_issue_if.sv
// AR issue bundle: upstream handshake, ID-table lookup/push, downstream issue and stall count.
// The DUT connects through the slave modport and the environment through the master modport.
interface axi_demux_ar_issue_if #(
   parameter int unsigned AxiLookBits = 3,
   parameter int unsigned NoMstPorts  = 4,
   parameter int unsigned SelWidth    = 2,
   parameter int unsigned CntWidth    = 4
);
   logic                   slv_ar_valid_i;
   logic                   slv_ar_ready_o;
   logic [AxiLookBits-1:0] slv_ar_id_i;
   logic [SelWidth-1:0]    slv_ar_sel_i;

   logic [AxiLookBits-1:0] lookup_axi_id_o;
   logic                   lookup_sel_taken_i;
   logic [SelWidth-1:0]    lookup_sel_i;
   logic [CntWidth-1:0]    in_flight_cnt_i;

   logic                   push_en_o;
   logic [AxiLookBits-1:0] push_axi_id_o;
   logic [SelWidth-1:0]    push_sel_o;

   logic [NoMstPorts-1:0]  mst_ar_valid_o;
   logic [NoMstPorts-1:0]  mst_ar_ready_i;
   logic [AxiLookBits-1:0] mst_ar_id_o;

   logic [15:0]            stall_cnt_o;

   modport slave (
      input  slv_ar_valid_i, slv_ar_id_i, slv_ar_sel_i,
             lookup_sel_taken_i, lookup_sel_i, in_flight_cnt_i, mst_ar_ready_i,
      output slv_ar_ready_o, lookup_axi_id_o, push_en_o, push_axi_id_o, push_sel_o,
             mst_ar_valid_o, mst_ar_id_o, stall_cnt_o
   );

   modport master (
      output slv_ar_valid_i, slv_ar_id_i, slv_ar_sel_i,
             lookup_sel_taken_i, lookup_sel_i, in_flight_cnt_i, mst_ar_ready_i,
      input  slv_ar_ready_o, lookup_axi_id_o, push_en_o, push_axi_id_o, push_sel_o,
             mst_ar_valid_o, mst_ar_id_o, stall_cnt_o
   );
endinterface

// File: rtl/axi_demux_ar_issue.sv
// AR channel issue stage of an AXI demux: checks ID ordering and the outstanding limit,
// pushes into the in-flight table, then holds a one-hot AR valid on the selected master port.
module axi_demux_ar_issue #(
   parameter int unsigned AxiLookBits = 3,
   parameter int unsigned NoMstPorts  = 4,
   parameter int unsigned SelWidth    = 2,
   parameter int unsigned CntWidth    = 4,
   parameter int unsigned MaxTrans    = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   axi_demux_ar_issue_if.slave   bus
);
   typedef enum logic {IDLE, HOLD} state_e;

   localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxTrans);

   state_e                 state_q;
   logic [AxiLookBits-1:0] id_q;
   logic [SelWidth-1:0]    sel_q;
   logic [15:0]            stall_q;

   logic                   block_cond;
   logic                   blocked;
   logic                   ready;
   logic                   handshake;
   logic [NoMstPorts-1:0]  valid_vec;
   logic                   sel_ready;

   always_comb begin
      block_cond = (bus.lookup_sel_taken_i && (bus.lookup_sel_i != bus.slv_ar_sel_i))
                   || (bus.in_flight_cnt_i >= MaxCnt);
      // Qualified by valid so idle request fields never influence ready or the stall count.
      blocked    = bus.slv_ar_valid_i && block_cond;
      ready      = (state_q == IDLE) && !rst_i && !blocked;
      handshake  = ready && bus.slv_ar_valid_i;

      valid_vec = '0;
      for (int unsigned i = 0; i < NoMstPorts; i++) begin
         valid_vec[i] = (state_q == HOLD) && (sel_q == SelWidth'(i));
      end
      sel_ready = |(valid_vec & bus.mst_ar_ready_i);
   end

   assign bus.lookup_axi_id_o = bus.slv_ar_id_i;
   assign bus.slv_ar_ready_o  = ready;
   assign bus.push_en_o       = handshake;
   assign bus.push_axi_id_o   = bus.slv_ar_id_i;
   assign bus.push_sel_o      = bus.slv_ar_sel_i;
   assign bus.mst_ar_valid_o  = valid_vec;
   assign bus.mst_ar_id_o     = id_q;
   assign bus.stall_cnt_o     = stall_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         id_q    <= '0;
         sel_q   <= '0;
         stall_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (handshake) begin
                  id_q    <= bus.slv_ar_id_i;
                  sel_q   <= bus.slv_ar_sel_i;
                  state_q <= HOLD;
               end
               if (blocked && (stall_q != '1)) begin
                  stall_q <= stall_q + 16'd1;
               end
            end
            HOLD: begin
               if (sel_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_demux_ar_issue.sv
// Directed bench for axi_demux_ar_issue: issue, ordering block, same-select pass,
// outstanding limit, stall saturation and asynchronous reset while holding.
module tb_axi_demux_ar_issue;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned tests = 0;
   int unsigned fails = 0;

   axi_demux_ar_issue_if #(.AxiLookBits(3), .NoMstPorts(4), .SelWidth(2), .CntWidth(4)) bus ();

   axi_demux_ar_issue #(
      .AxiLookBits(3), .NoMstPorts(4), .SelWidth(2), .CntWidth(4), .MaxTrans(8)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.slv_ar_valid_i     = 1'b0;
      bus.slv_ar_id_i        = '0;
      bus.slv_ar_sel_i       = '0;
      bus.lookup_sel_taken_i = 1'b0;
      bus.lookup_sel_i       = '0;
      bus.in_flight_cnt_i    = '0;
      bus.mst_ar_ready_i     = '0;

      // Reset state
      #2;
      chk("rst_ready", 32'(bus.slv_ar_ready_o), 32'd0);
      chk("rst_mvalid", 32'(bus.mst_ar_valid_o), 32'd0);
      chk("rst_push", 32'(bus.push_en_o), 32'd0);
      chk("rst_stall", 32'(bus.stall_cnt_o), 32'd0);
      tick();
      tick();
      rst = 1'b0;

      // Basic issue, first cycle out of reset
      bus.slv_ar_valid_i = 1'b1;
      bus.slv_ar_id_i    = 3'd3;
      bus.slv_ar_sel_i   = 2'd2;
      #1;
      chk("basic_ready", 32'(bus.slv_ar_ready_o), 32'd1);
      chk("basic_push", 32'(bus.push_en_o), 32'd1);
      chk("basic_push_id", 32'(bus.push_axi_id_o), 32'd3);
      chk("basic_push_sel", 32'(bus.push_sel_o), 32'd2);
      chk("basic_lookup_id", 32'(bus.lookup_axi_id_o), 32'd3);
      chk("basic_mvalid0", 32'(bus.mst_ar_valid_o), 32'd0);
      tick();
      bus.slv_ar_valid_i = 1'b0;
      bus.slv_ar_id_i    = 3'd6;
      bus.mst_ar_ready_i = 4'b1011;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("basic_hold_valid", 32'(bus.mst_ar_valid_o), 32'h4);
         chk("basic_hold_id", 32'(bus.mst_ar_id_o), 32'd3);
         chk("basic_hold_ready", 32'(bus.slv_ar_ready_o), 32'd0);
         chk("basic_hold_push", 32'(bus.push_en_o), 32'd0);
         tick();
      end
      bus.mst_ar_ready_i = 4'b0100;
      #1;
      chk("basic_acc_valid", 32'(bus.mst_ar_valid_o), 32'h4);
      tick();
      bus.mst_ar_ready_i = 4'b0000;
      #1;
      chk("basic_idle_valid", 32'(bus.mst_ar_valid_o), 32'd0);
      chk("basic_idle_ready", 32'(bus.slv_ar_ready_o), 32'd1);
      chk("basic_stall", 32'(bus.stall_cnt_o), 32'd0);

      // Ordering block: ID taken on port 1, request to port 2
      bus.slv_ar_valid_i     = 1'b1;
      bus.slv_ar_id_i        = 3'd5;
      bus.slv_ar_sel_i       = 2'd2;
      bus.lookup_sel_taken_i = 1'b1;
      bus.lookup_sel_i       = 2'd1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("ord_ready", 32'(bus.slv_ar_ready_o), 32'd0);
         chk("ord_push", 32'(bus.push_en_o), 32'd0);
         tick();
      end
      chk("ord_stall", 32'(bus.stall_cnt_o), 32'd5);
      bus.lookup_sel_taken_i = 1'b0;
      #1;
      chk("ord_rel_ready", 32'(bus.slv_ar_ready_o), 32'd1);
      chk("ord_rel_push", 32'(bus.push_en_o), 32'd1);
      tick();
      bus.slv_ar_valid_i = 1'b0;
      bus.mst_ar_ready_i = 4'b0100;
      chk("ord_mvalid", 32'(bus.mst_ar_valid_o), 32'h4);
      chk("ord_mid", 32'(bus.mst_ar_id_o), 32'd5);
      chk("ord_stall_hold", 32'(bus.stall_cnt_o), 32'd5);
      tick();

      // Same select passes while taken
      bus.mst_ar_ready_i     = 4'b0000;
      bus.slv_ar_valid_i     = 1'b1;
      bus.lookup_sel_taken_i = 1'b1;
      bus.lookup_sel_i       = 2'd2;
      #1;
      chk("same_ready", 32'(bus.slv_ar_ready_o), 32'd1);
      chk("same_push", 32'(bus.push_en_o), 32'd1);
      tick();
      bus.slv_ar_valid_i     = 1'b0;
      bus.lookup_sel_taken_i = 1'b0;
      chk("same_stall", 32'(bus.stall_cnt_o), 32'd5);
      chk("same_mvalid", 32'(bus.mst_ar_valid_o), 32'h4);
      bus.mst_ar_ready_i = 4'b0100;
      tick();
      bus.mst_ar_ready_i = 4'b0000;

      // Outstanding limit
      bus.slv_ar_valid_i  = 1'b1;
      bus.slv_ar_id_i     = 3'd1;
      bus.slv_ar_sel_i    = 2'd1;
      bus.in_flight_cnt_i = 4'd7;
      #1;
      chk("cnt7_ready", 32'(bus.slv_ar_ready_o), 32'd1);
      tick();
      bus.slv_ar_valid_i = 1'b0;
      chk("cnt7_mvalid", 32'(bus.mst_ar_valid_o), 32'h2);
      bus.mst_ar_ready_i = 4'b0010;
      tick();
      bus.mst_ar_ready_i  = 4'b0000;
      bus.slv_ar_valid_i  = 1'b1;
      bus.in_flight_cnt_i = 4'd8;
      #1;
      chk("cnt8_ready", 32'(bus.slv_ar_ready_o), 32'd0);
      chk("cnt8_push", 32'(bus.push_en_o), 32'd0);
      tick();
      bus.in_flight_cnt_i = 4'd15;
      #1;
      chk("cnt15_ready", 32'(bus.slv_ar_ready_o), 32'd0);
      tick();
      chk("cnt_stall", 32'(bus.stall_cnt_o), 32'd7);

      // Saturation under a sustained block
      bus.in_flight_cnt_i = 4'd8;
      repeat (70000) tick();
      chk("sat_stall", 32'(bus.stall_cnt_o), 32'hFFFF);
      tick();
      chk("sat_nowrap", 32'(bus.stall_cnt_o), 32'hFFFF);

      // Asynchronous reset while holding port 0
      bus.in_flight_cnt_i = 4'd0;
      bus.slv_ar_id_i     = 3'd2;
      bus.slv_ar_sel_i    = 2'd0;
      #1;
      chk("rh_ready", 32'(bus.slv_ar_ready_o), 32'd1);
      tick();
      bus.slv_ar_valid_i = 1'b0;
      chk("rh_mvalid", 32'(bus.mst_ar_valid_o), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("rh_async_mvalid", 32'(bus.mst_ar_valid_o), 32'd0);
      chk("rh_async_stall", 32'(bus.stall_cnt_o), 32'd0);
      chk("rh_async_ready", 32'(bus.slv_ar_ready_o), 32'd0);
      chk("rh_async_push", 32'(bus.push_en_o), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("rh_idle_ready", 32'(bus.slv_ar_ready_o), 32'd1);
      chk("rh_idle_mvalid", 32'(bus.mst_ar_valid_o), 32'd0);
      bus.slv_ar_valid_i = 1'b1;
      bus.slv_ar_id_i    = 3'd4;
      bus.slv_ar_sel_i   = 2'd3;
      #1;
      chk("rh_first_push", 32'(bus.push_en_o), 32'd1);
      tick();
      bus.slv_ar_valid_i = 1'b0;
      chk("rh_first_mvalid", 32'(bus.mst_ar_valid_o), 32'h8);
      chk("rh_first_mid", 32'(bus.mst_ar_id_o), 32'd4);
      chk("rh_first_stall", 32'(bus.stall_cnt_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
